mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, 4, number of consecutive data grants taken while a fetch waits before the fetch is forced to win; legal range 1..15.
REQ-002 clk  input  1  the single clock; every register is rising-edge triggered.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch request, held by the fetch stage while if_wait=1.
REQ-005 if_addr  input  32  fetch address, word-aligned, stable while if_req=1.
REQ-006 if_rdata  output  32  fetched instruction.
REQ-007 if_wait  output  1  inst_mem_wait to the hazard unit.
REQ-008 dm_req, dm_we  input  1 each  data request and write enable.
REQ-009 dm_addr, dm_wdata  input  32 each  data address and write data.
REQ-010 dm_be  input  4  byte enables.
REQ-011 dm_rdata  output  32  load data.
REQ-012 dm_wait  output  1  data_mem_wait to the hazard unit.
REQ-013 bus_stb, bus_we  output  1 each  registered bus strobe and write enable.
REQ-014 bus_addr, bus_wdata  output  32 each  registered bus address and write data.
REQ-015 bus_sel  output  4  registered byte select.
REQ-016 bus_ack  input  1  slave completion, valid only while bus_stb=1.
REQ-017 bus_rdata  input  32  slave read data, valid with bus_ack.

Function
REQ-018 FSM states IDLE, IF_ACC and DM_ACC; exactly one state is active.
REQ-019 In IDLE with only dm_req set, the next state is DM_ACC.
REQ-020 In IDLE with only if_req set, the next state is IF_ACC.
REQ-021 In IDLE with both requests set, the next state is DM_ACC unless starve_cnt==STARVE_LIMIT, in which case it is IF_ACC.
REQ-022 On a grant edge, bus_stb goes to 1 and bus_addr/bus_we/bus_wdata/bus_sel are loaded from the winner; a fetch loads bus_we=0 and bus_sel=4'hF.
REQ-023 Bus outputs hold constant for the whole of IF_ACC/DM_ACC.
REQ-024 IF_ACC/DM_ACC exits to IDLE on the edge where bus_ack=1, with bus_stb cleared on that edge; with no ack the state waits indefinitely.
REQ-025 The arbiter always spends at least one IDLE cycle between accesses, so a grant is never issued in the ack cycle.
REQ-026 if_wait = if_req AND NOT (state==IF_ACC AND bus_ack); the same rule applies to dm_wait with DM_ACC. Both are combinational.
REQ-027 While the matching ack is high, if_rdata/dm_rdata pass bus_rdata through.
REQ-028 Otherwise if_rdata/dm_rdata show their holding registers, which are loaded from bus_rdata on the matching ack edge.
REQ-029 Best-case latency: request in cycle N, bus_stb in N+1, ack in N+1, so wait is low in N+1.
REQ-030 A 4-bit starve_cnt increments, saturating at STARVE_LIMIT, on each DM grant taken while if_req=1.
REQ-031 starve_cnt clears on each IF grant.
REQ-032 A started bus access always completes even if its request drops, for example on a flush; the data is still latched, and the wait for a deasserted request is 0.
REQ-033 A request that rises while the other port's access is in flight waits with wait=1 and is arbitrated in the next IDLE cycle.
REQ-034 dm_we=1 accesses update dm_rdata from bus_rdata the same way as reads; the content is don't-care.

Reset
REQ-035 Asserting rst_n=0, including mid-access, immediately forces state=IDLE, bus_stb=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_sel=0, starve_cnt=0 and both holding registers to 0.
REQ-036 While reset is asserted, if_wait=if_req and dm_wait=dm_req.
REQ-037 An access that was in flight when reset asserted is abandoned, and a bus_ack arriving after reset is ignored.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x100, ack one cycle after stb with rdata=0x00000013 -> if_wait is 1 then 0, if_rdata=0x13, bus_sel=F, bus_we=0.
REQ-039 Simultaneous requests: if_req and dm_req with dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF, dm_be=0x3 -> DM granted first with bus_sel=3, IF granted next, one IDLE cycle between.
REQ-040 Starvation: dm_req held continuously with if_req=1 and STARVE_LIMIT=4 -> four DM grants, then an IF grant, then starve_cnt=0.
REQ-041 Slow slave: ack delayed 5 cycles -> bus_* outputs stable for 6 cycles, dm_wait high until the ack cycle.
REQ-042 Flush: if_req drops during IF_ACC -> the bus cycle still completes, if_wait=0, and the next grant is correct.
REQ-043 Reset mid-access: rst_n low during DM_ACC -> bus_stb is 0 within the same cycle, the FSM is in IDLE after release, and a late ack has no effect.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data port arbiter onto a single registered strobe/ack bus

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_wait,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_wait,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IF_ACC = 2'd1;
    localparam logic [1:0] S_DM_ACC = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  r_state;
    logic [3:0]  r_starve_cnt;
    logic        r_bus_stb;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_if_hold;
    logic [31:0] r_dm_hold;

    logic w_if_ack;
    logic w_dm_ack;
    logic w_grant_dm;
    logic w_grant_if;

    assign w_if_ack = (r_state == S_IF_ACC) && bus_ack;
    assign w_dm_ack = (r_state == S_DM_ACC) && bus_ack;

    // Data wins a contest unless the fetch has already been passed over LIMIT times.
    assign w_grant_dm = (r_state == S_IDLE) && dm_req && !(if_req && (r_starve_cnt == LIMIT));
    assign w_grant_if = (r_state == S_IDLE) && if_req && !w_grant_dm;

    assign if_wait  = if_req && !w_if_ack;
    assign dm_wait  = dm_req && !w_dm_ack;
    assign if_rdata = w_if_ack ? bus_rdata : r_if_hold;
    assign dm_rdata = w_dm_ack ? bus_rdata : r_dm_hold;

    assign bus_stb   = r_bus_stb;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_sel   = r_bus_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            r_bus_stb    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_wdata  <= 32'd0;
            r_bus_sel    <= 4'd0;
            r_if_hold    <= 32'd0;
            r_dm_hold    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_dm) begin
                        r_state     <= S_DM_ACC;
                        r_bus_stb   <= 1'b1;
                        r_bus_we    <= dm_we;
                        r_bus_addr  <= dm_addr;
                        r_bus_wdata <= dm_wdata;
                        r_bus_sel   <= dm_be;
                        if (if_req && (r_starve_cnt < LIMIT)) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end else if (w_grant_if) begin
                        r_state      <= S_IF_ACC;
                        r_bus_stb    <= 1'b1;
                        r_bus_we     <= 1'b0;
                        r_bus_addr   <= if_addr;
                        r_bus_wdata  <= 32'd0;
                        r_bus_sel    <= 4'hF;
                        r_starve_cnt <= 4'd0;
                    end
                end
                // Accesses complete even if the request has dropped, so data is always captured.
                S_IF_ACC: begin
                    if (bus_ack) begin
                        r_state   <= S_IDLE;
                        r_bus_stb <= 1'b0;
                        r_if_hold <= bus_rdata;
                    end
                end
                S_DM_ACC: begin
                    if (bus_ack) begin
                        r_state   <= S_IDLE;
                        r_bus_stb <= 1'b0;
                        r_dm_hold <= bus_rdata;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bus_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table, corner sequences and randomized model check for mem_arbiter

module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, dm_req, dm_we, bus_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, bus_rdata;
    logic [3:0]  dm_be;
    logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
    logic        if_wait, dm_wait, bus_stb, bus_we;
    logic [3:0]  bus_sel;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_wait(if_wait),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_wait(dm_wait),
        .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_be;
        logic        ack;
        logic [31:0] rdata;
        logic        e_if_wait;
        logic        e_dm_wait;
        logic        e_stb;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic [31:0] e_wdata;
        logic [31:0] e_if_rdata;
        logic [31:0] e_dm_rdata;
    } vec_t;

    vec_t vecs[9];
    int   starve_pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int   grants[10];
    int   n_grants;

    // Transaction-level reference: who owns the bus, what was granted, and the stored read data.
    logic        m_busy, m_owner_dm, m_we, pick_if, ack_if, ack_dm, if_done, dm_done;
    logic [31:0] m_addr, m_wdata, m_if_hold, m_dm_hold;
    logic [3:0]  m_sel;
    int          m_passed_over;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
        dm_wdata = 0; dm_be = 0; bus_ack = 0; bus_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        if_req = 1; dm_req = 1;
        rst_n = 0;
        #1;
        chk("reset if_wait follows if_req", if_wait, 1);
        chk("reset dm_wait follows dm_req", dm_wait, 1);
        tick();
        chk("reset bus_stb", bus_stb, 0);
        chk("reset bus_we", bus_we, 0);
        chk("reset bus_addr", bus_addr, 0);
        chk("reset bus_wdata", bus_wdata, 0);
        chk("reset bus_sel", bus_sel, 0);
        chk("reset if_rdata", if_rdata, 0);
        chk("reset dm_rdata", dm_rdata, 0);
        idle_inputs();
        tick();
        rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        // fields: if_req if_addr dm_req dm_we dm_addr dm_wdata dm_be ack rdata |
        //         if_wait dm_wait stb we addr sel wdata if_rdata dm_rdata
        vecs[0] = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,           1, 0, 1, 0, 32'h100, 4'hF, 0, 0, 0};
        vecs[2] = '{1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h13,      0, 0, 1, 0, 32'h100, 4'hF, 0, 32'h13, 0};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF,      0, 0, 0, 0, 0, 0, 0, 32'h13, 0};
        vecs[4] = '{1, 32'h200, 1, 1, 32'h2000, 32'hDEADBEEF, 4'h3, 0, 0,
                    1, 1, 0, 0, 0, 0, 0, 32'h13, 0};
        vecs[5] = '{1, 32'h200, 1, 1, 32'h2000, 32'hDEADBEEF, 4'h3, 1, 32'h55,
                    1, 0, 1, 1, 32'h2000, 4'h3, 32'hDEADBEEF, 32'h13, 32'h55};
        vecs[6] = '{1, 32'h200, 0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 32'h13, 32'h55};
        vecs[7] = '{1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h77,      0, 0, 1, 0, 32'h200, 4'hF, 0, 32'h77, 32'h55};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 32'h77, 32'h55};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we; dm_addr = vecs[i].dm_addr;
            dm_wdata = vecs[i].dm_wdata; dm_be = vecs[i].dm_be;
            bus_ack = vecs[i].ack; bus_rdata = vecs[i].rdata;
            #2;
            chk($sformatf("vec%0d if_wait", i), if_wait, vecs[i].e_if_wait);
            chk($sformatf("vec%0d dm_wait", i), dm_wait, vecs[i].e_dm_wait);
            chk($sformatf("vec%0d bus_stb", i), bus_stb, vecs[i].e_stb);
            chk($sformatf("vec%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
            chk($sformatf("vec%0d dm_rdata", i), dm_rdata, vecs[i].e_dm_rdata);
            if (vecs[i].e_stb) begin
                chk($sformatf("vec%0d bus_we", i), bus_we, vecs[i].e_we);
                chk($sformatf("vec%0d bus_addr", i), bus_addr, vecs[i].e_addr);
                chk($sformatf("vec%0d bus_sel", i), bus_sel, vecs[i].e_sel);
                if (vecs[i].e_we) chk($sformatf("vec%0d bus_wdata", i), bus_wdata, vecs[i].e_wdata);
            end
            tick();
        end

        // Starvation: both ports hold requests, the slave acks every strobe immediately.
        do_reset();
        if_req = 1; if_addr = 32'h300; dm_req = 1; dm_addr = 32'h400; dm_be = 4'hF;
        n_grants = 0;
        for (int c = 0; c < 200 && n_grants < 10; c++) begin
            bus_ack = bus_stb;
            bus_rdata = c;
            #2;
            if (bus_stb) begin
                grants[n_grants] = (bus_addr == 32'h400) ? 1 : 0;
                n_grants++;
            end
            tick();
        end
        chk("starve grant count", n_grants, 10);
        for (int i = 0; i < n_grants; i++) chk($sformatf("starve grant%0d is_dm", i), grants[i], starve_pat[i]);

        // Slow slave: ack arrives on the sixth strobe cycle.
        do_reset();
        dm_req = 1; dm_we = 1; dm_addr = 32'h500; dm_wdata = 32'h12345678; dm_be = 4'hC;
        #2;
        chk("slow pre-grant dm_wait", dm_wait, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            bus_ack = (i == 5);
            bus_rdata = (i == 5) ? 32'hCAFE0000 : 32'h0BAD0000;
            #2;
            chk($sformatf("slow c%0d bus_stb", i), bus_stb, 1);
            chk($sformatf("slow c%0d bus_addr", i), bus_addr, 32'h500);
            chk($sformatf("slow c%0d bus_wdata", i), bus_wdata, 32'h12345678);
            chk($sformatf("slow c%0d bus_sel", i), bus_sel, 4'hC);
            chk($sformatf("slow c%0d bus_we", i), bus_we, 1);
            chk($sformatf("slow c%0d dm_wait", i), dm_wait, (i < 5));
            tick();
        end
        idle_inputs();
        #2;
        chk("slow after bus_stb", bus_stb, 0);
        chk("slow after dm_rdata", dm_rdata, 32'hCAFE0000);
        tick();

        // Flush: fetch drops mid-access while a data request arrives.
        do_reset();
        if_req = 1; if_addr = 32'h600;
        tick();
        if_req = 0; dm_req = 1; dm_addr = 32'h700; dm_be = 4'hF;
        #2;
        chk("flush if_wait dropped", if_wait, 0);
        chk("flush bus_stb held", bus_stb, 1);
        chk("flush bus_addr", bus_addr, 32'h600);
        chk("flush dm_wait in flight", dm_wait, 1);
        tick();
        bus_ack = 1; bus_rdata = 32'hABCD0001;
        #2;
        chk("flush ack dm_wait", dm_wait, 1);
        tick();
        bus_ack = 0; bus_rdata = 0;
        #2;
        chk("flush idle bus_stb", bus_stb, 0);
        chk("flush latched if_rdata", if_rdata, 32'hABCD0001);
        tick();
        bus_ack = 1; bus_rdata = 32'h11;
        #2;
        chk("flush next grant bus_stb", bus_stb, 1);
        chk("flush next grant addr", bus_addr, 32'h700);
        chk("flush next grant we", bus_we, 0);
        chk("flush next dm_wait", dm_wait, 0);
        chk("flush next dm_rdata", dm_rdata, 32'h11);
        tick();

        // Reset mid-access, then a late ack.
        do_reset();
        dm_req = 1; dm_we = 1; dm_addr = 32'h800; dm_wdata = 32'h5A5A5A5A; dm_be = 4'hF;
        tick();
        chk("rstmid stb before reset", bus_stb, 1);
        #1;
        rst_n = 0;
        #1;
        chk("rstmid bus_stb cleared", bus_stb, 0);
        chk("rstmid bus_addr cleared", bus_addr, 0);
        chk("rstmid dm_wait", dm_wait, 1);
        tick();
        dm_req = 0; dm_we = 0;
        rst_n = 1;
        bus_ack = 1; bus_rdata = 32'h99999999;
        #2;
        chk("rstmid late ack dm_rdata", dm_rdata, 0);
        chk("rstmid late ack dm_wait", dm_wait, 0);
        tick();
        idle_inputs();
        #2;
        chk("rstmid after bus_stb", bus_stb, 0);
        chk("rstmid after dm_rdata", dm_rdata, 0);
        tick();

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_busy = 0; m_owner_dm = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_sel = 0;
        m_if_hold = 0; m_dm_hold = 0; m_passed_over = 0;
        if_done = 0; dm_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (if_req && if_done) if_req = 0;
            if (dm_req && dm_done) dm_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!dm_req && $urandom_range(0, 1) == 0) begin
                dm_req = 1; dm_we = $urandom_range(0, 1) == 1; dm_addr = $urandom() & 32'hFFFF_FFFC;
                dm_wdata = $urandom(); dm_be = 4'($urandom_range(1, 15));
            end
            bus_ack = m_busy && ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom();
            #2;
            ack_if = m_busy && !m_owner_dm && bus_ack;
            ack_dm = m_busy && m_owner_dm && bus_ack;
            chk("rnd if_wait", if_wait, if_req && !ack_if);
            chk("rnd dm_wait", dm_wait, dm_req && !ack_dm);
            chk("rnd if_rdata", if_rdata, ack_if ? bus_rdata : m_if_hold);
            chk("rnd dm_rdata", dm_rdata, ack_dm ? bus_rdata : m_dm_hold);
            chk("rnd bus_stb", bus_stb, m_busy);
            if (m_busy) begin
                chk("rnd bus_addr", bus_addr, m_addr);
                chk("rnd bus_we", bus_we, m_we);
                chk("rnd bus_sel", bus_sel, m_sel);
                if (m_we) chk("rnd bus_wdata", bus_wdata, m_wdata);
            end
            if_done = if_req && ack_if;
            dm_done = dm_req && ack_dm;
            if (m_busy) begin
                if (bus_ack) begin
                    m_busy = 0;
                    if (m_owner_dm) m_dm_hold = bus_rdata;
                    else m_if_hold = bus_rdata;
                end
            end else if (if_req || dm_req) begin
                pick_if = if_req && (!dm_req || m_passed_over == LIMIT);
                m_busy = 1;
                m_owner_dm = !pick_if;
                if (pick_if) begin
                    m_we = 0; m_addr = if_addr; m_sel = 4'hF; m_passed_over = 0;
                end else begin
                    m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_sel = dm_be;
                    if (if_req && m_passed_over < LIMIT) m_passed_over++;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
